// File: rtl/iir_sched_pkg.sv
// iir_sched_pkg: filter coefficients, FSM states and the truncate-toward-zero
// Q10 rescale shared by iir_sched.
package iir_sched_pkg;
  localparam int FRAC_BITS = 10;
  localparam int B0 = 178;
  localparam int B1 = 178;
  localparam int A1 = -666;
  localparam int PW = 128;
  typedef enum logic [2:0] {IDLE, READ, MUL0, MUL1, MUL2, WRITE} state_t;
  // Biasing negatives before the shift makes it round toward zero like a divide.
  function automatic logic signed [PW-1:0] dq(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] bias;
    bias = p[PW-1] ? PW'((1 << FRAC_BITS) - 1) : PW'(0);
    return (p + bias) >>> FRAC_BITS;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; last holds the most recent grant.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt,
  output logic       any
);
  logic last;
  assign any = |req;
  assign gnt = &req ? ~last : req[1];
  always_ff @(posedge clock or negedge reset)
    if (!reset) last <= 1'b1;
    else if (take && any) last <= gnt;
endmodule

// File: rtl/iir_sched.sv
// iir_sched: first-order IIR shared across two channels with one multiplier,
// fed from per-channel input FIFOs and writing per-channel output FIFOs.
module iir_sched
  import iir_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH = 2
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    in_dout,
  input  logic [NUM_CH-1:0]                    in_empty,
  output logic [NUM_CH-1:0]                    in_rd_en,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0]    out_din,
  input  logic [NUM_CH-1:0]                    out_full,
  output logic [NUM_CH-1:0]                    out_wr_en,
  input  logic                                 clr,
  output logic                                 busy
);
  localparam int W = DATA_WIDTH;
  typedef logic signed [W-1:0] word_t;
  state_t state, state_nx;
  logic ch, gnt, any, take;
  logic [NUM_CH-1:0] elig;
  word_t x, acc, mul_a, mul_b, dq_w;
  word_t xp [NUM_CH];
  word_t yp [NUM_CH];
  word_t held [NUM_CH];
  logic signed [2*W-1:0] prod;
  assign elig = ~in_empty & ~out_full;
  assign take = state == IDLE && !clr;
  rr_arb2 u_arb (
    .clock(clock),
    .reset(reset),
    .req(elig),
    .take(take),
    .gnt(gnt),
    .any(any)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (!clr && any) ? READ : IDLE;
      READ:    state_nx = MUL0;
      MUL0:    state_nx = MUL1;
      MUL1:    state_nx = MUL2;
      MUL2:    state_nx = WRITE;
      default: state_nx = IDLE;
    endcase
    mul_a = state == MUL0 ? word_t'(in_dout[ch]) : state == MUL1 ? xp[ch] : yp[ch];
    mul_b = state == MUL0 ? word_t'(B0) : state == MUL1 ? word_t'(B1) : word_t'(A1);
    prod = (2*W)'(mul_a) * (2*W)'(mul_b);
    dq_w = W'(dq(PW'(prod)));
    in_rd_en = state == READ ? NUM_CH'(1) << ch : '0;
    out_wr_en = state == WRITE ? NUM_CH'(1) << ch : '0;
    busy = state != IDLE;
    // Idle channels keep presenting their last written sample.
    for (int c = 0; c < NUM_CH; c++)
      out_din[c] = (state == WRITE && ch == 1'(c)) ? acc : held[c];
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ch <= 1'b0;
      x <= '0;
      acc <= '0;
      xp <= '{default: '0};
      yp <= '{default: '0};
      held <= '{default: '0};
    end else begin
      state <= state_nx;
      if (take && any) ch <= gnt;
      if (state == IDLE && clr) begin
        xp <= '{default: '0};
        yp <= '{default: '0};
      end
      if (state == MUL0) begin
        x <= word_t'(in_dout[ch]);
        acc <= dq_w;
      end
      if (state == MUL1) acc <= acc + dq_w;
      if (state == MUL2) acc <= acc - dq_w;
      if (state == WRITE) begin
        xp[ch] <= x;
        yp[ch] <= acc;
        held[ch] <= acc;
      end
    end
endmodule

// File: tb/tb_iir_sched.sv
// tb_iir_sched: FIFO models around iir_sched, checked against a plain-arithmetic filter model.
module tb_iir_sched;
  localparam int W = 32;
  logic clock = 1'b0, reset = 1'b0, clr = 1'b0, busy;
  logic [1:0][W-1:0] in_dout = '0;
  logic [1:0][W-1:0] out_din;
  logic [1:0] in_empty = 2'b11, out_full = 2'b00, in_rd_en, out_wr_en;
  int inq[2][$], expq[2][$], obs[2][$];
  int xp_m[2], yp_m[2];
  int wr_ch[$], wr_cyc[$], rd_ch[$], rd_cyc[$];
  int cyc = 0, viol = 0, checks = 0, passes = 0;

  iir_sched #(.DATA_WIDTH(W), .NUM_CH(2)) dut (
    .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .out_din(out_din), .out_full(out_full),
    .out_wr_en(out_wr_en), .clr(clr), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    for (int c = 0; c < 2; c++)
      if (in_rd_en[c] && inq[c].size() > 0) in_dout[c] <= inq[c].pop_front();
  end

  always @(negedge clock) begin
    for (int c = 0; c < 2; c++) begin
      in_empty[c] = inq[c].size() == 0;
      if (out_wr_en[c]) begin
        obs[c].push_back(int'(out_din[c]));
        wr_ch.push_back(c);
        wr_cyc.push_back(cyc);
      end
      if (in_rd_en[c]) begin
        rd_ch.push_back(c);
        rd_cyc.push_back(cyc);
      end
    end
    if ($countones(in_rd_en) > 1 || $countones(out_wr_en) > 1 || (|in_rd_en && |out_wr_en)) viol++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  // Reference filter: y = x*B0/1024 + xp*B1/1024 - yp*A1/1024, each term truncated toward zero.
  task automatic push(input int c, input int x);
    int y;
    y = int'(longint'(x) * 178 / 1024) + int'(longint'(xp_m[c]) * 178 / 1024)
      - int'(longint'(yp_m[c]) * (-666) / 1024);
    xp_m[c] = x;
    yp_m[c] = y;
    inq[c].push_back(x);
    expq[c].push_back(y);
  endtask

  function automatic int rv();
    return $urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic clear_all();
    for (int c = 0; c < 2; c++) begin
      inq[c].delete(); expq[c].delete(); obs[c].delete();
      xp_m[c] = 0; yp_m[c] = 0;
    end
    wr_ch.delete(); wr_cyc.delete(); rd_ch.delete(); rd_cyc.delete();
    viol = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    out_full = 2'b00;
    clr = 1'b0;
    clear_all();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_obs(input int c, input int n, output bit ok);
    for (int i = 0; i < 400 && obs[c].size() < n; i++) begin @(negedge clock); #1; end
    ok = obs[c].size() >= n;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (in_rd_en !== 2'b00) $display("FAIL reset_rd_en: got %b want 00", in_rd_en); else passes++;
    checks++; if (out_wr_en !== 2'b00) $display("FAIL reset_wr_en: got %b want 00", out_wr_en); else passes++;
    checks++; if (out_din !== '0) $display("FAIL reset_out_din: got %h want 0", out_din); else passes++;
    push(0, 5);
    repeat (3) @(negedge clock);
    #1;
    checks++; if (in_rd_en !== 2'b00 || rd_ch.size() != 0) $display("FAIL reset_hold_rd: got %0d reads want 0", rd_ch.size()); else passes++;
    clear_all();
  endtask

  task automatic test_arbitration();
    @(negedge clock);
    reset = 1'b0;
    clear_all();
    for (int i = 0; i < 4; i++) push(i % 2, int'($urandom_range(0, 8191)) - 4096);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 400 && wr_ch.size() < 4; i++) begin @(negedge clock); #1; end
    checks++;
    if (wr_ch.size() < 4 || rd_ch.size() < 4) $display("FAIL arb_timeout: got %0d writes want 4", wr_ch.size());
    else begin
      passes++;
      for (int i = 0; i < 4; i++) begin
        checks++; if (wr_ch[i] != i % 2) $display("FAIL arb_order[%0d]: got ch%0d want ch%0d", i, wr_ch[i], i % 2); else passes++;
        checks++; if (wr_cyc[i] - rd_cyc[i] != 4) $display("FAIL arb_latency[%0d]: got %0d want 4", i, wr_cyc[i] - rd_cyc[i]); else passes++;
      end
      for (int i = 0; i < 3; i++) begin
        checks++; if (wr_cyc[i+1] - wr_cyc[i] != 6) $display("FAIL arb_period[%0d]: got %0d want 6", i, wr_cyc[i+1] - wr_cyc[i]); else passes++;
      end
      for (int c = 0; c < 2; c++)
        for (int j = 0; j < 2; j++) begin
          checks++; if (obs[c][j] != expq[c][j]) $display("FAIL arb_value ch%0d[%0d]: got %0d want %0d", c, j, obs[c][j], expq[c][j]); else passes++;
        end
    end
  endtask

  task automatic test_impulse();
    bit ok;
    int want[3] = '{178, 293, 190};
    do_reset();
    push(0, 1024); push(0, 0); push(0, 0);
    wait_obs(0, 3, ok);
    checks++; if (!ok) $display("FAIL impulse_timeout: got %0d writes want 3", obs[0].size()); else passes++;
    if (ok)
      for (int i = 0; i < 3; i++) begin
        checks++; if (obs[0][i] != want[i]) $display("FAIL impulse[%0d]: got %0d want %0d", i, obs[0][i], want[i]); else passes++;
      end
  endtask

  task automatic test_rounding();
    bit ok;
    do_reset();
    push(1, -1);
    wait_obs(1, 1, ok);
    checks++; if (!ok) $display("FAIL rounding_timeout: no write on ch1"); else passes++;
    if (ok) begin
      checks++; if (obs[1][0] != 0) $display("FAIL rounding: got %0d want 0", obs[1][0]); else passes++;
      checks++; if (obs[0].size() != 0) $display("FAIL rounding_ch0_idle: got %0d writes want 0", obs[0].size()); else passes++;
    end
  endtask

  task automatic test_backpressure();
    bit ok, ok2;
    int rel, first0, n0;
    do_reset();
    out_full = 2'b01;
    for (int i = 0; i < 2; i++) push(0, rv());
    for (int i = 0; i < 4; i++) push(1, rv());
    wait_obs(1, 2, ok);
    n0 = 0;
    foreach (rd_ch[i]) if (rd_ch[i] == 0) n0++;
    checks++; if (!ok) $display("FAIL bp_timeout: got %0d ch1 writes want 2", obs[1].size()); else passes++;
    checks++; if (n0 != 0 || obs[0].size() != 0) $display("FAIL bp_blocked: got %0d ch0 reads want 0", n0); else passes++;
    @(negedge clock);
    out_full = 2'b00;
    rel = cyc;
    wait_obs(0, 2, ok);
    wait_obs(1, 4, ok2);
    checks++; if (!ok || !ok2) $display("FAIL bp_resume_timeout: got %0d/%0d writes want 2/4", obs[0].size(), obs[1].size()); else passes++;
    first0 = -1;
    foreach (rd_ch[i]) if (rd_ch[i] == 0 && first0 < 0) first0 = rd_cyc[i];
    checks++; if (first0 - rel < 1 || first0 - rel > 6) $display("FAIL bp_resume_delay: got %0d want 1..6", first0 - rel); else passes++;
    if (ok && ok2)
      for (int c = 0; c < 2; c++)
        foreach (obs[c][j]) begin
          checks++; if (obs[c][j] != expq[c][j]) $display("FAIL bp_value ch%0d[%0d]: got %0d want %0d", c, j, obs[c][j], expq[c][j]); else passes++;
        end
  endtask

  task automatic test_reset_midop();
    bit ok;
    do_reset();
    push(0, 1024);
    wait_obs(0, 1, ok);
    push(0, 0);
    for (int i = 0; i < 50 && in_rd_en[0] !== 1'b1; i++) begin @(negedge clock); #1; end
    checks++; if (in_rd_en[0] !== 1'b1) $display("FAIL midop_no_read: got %b want 1", in_rd_en[0]); else passes++;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (out_din !== '0 || out_wr_en !== 2'b00) $display("FAIL midop_outputs: got din=%h wr=%b want 0", out_din, out_wr_en); else passes++;
    checks++; if (busy !== 1'b0 || in_rd_en !== 2'b00) $display("FAIL midop_busy: got busy=%b rd=%b want 0", busy, in_rd_en); else passes++;
    repeat (3) @(negedge clock);
    #1;
    checks++; if (wr_ch.size() != 1) $display("FAIL midop_write: got %0d writes want 1", wr_ch.size()); else passes++;
    clear_all();
    @(negedge clock);
    reset = 1'b1;
    push(0, 1024);
    wait_obs(0, 1, ok);
    checks++; if (!ok || obs[0][0] != 178) $display("FAIL midop_after: got %0d want 178", ok ? obs[0][0] : -1); else passes++;
  endtask

  task automatic test_clear();
    bit ok;
    do_reset();
    push(0, 1024);
    wait_obs(0, 1, ok);
    for (int i = 0; i < 20 && busy; i++) begin @(negedge clock); #1; end
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    xp_m = '{0, 0};
    yp_m = '{0, 0};
    push(0, 0);
    wait_obs(0, 2, ok);
    checks++; if (!ok || obs[0][1] != 0) $display("FAIL clear_history: got %0d want 0", ok ? obs[0][1] : -1); else passes++;
    push(0, 1024);
    for (int i = 0; i < 20 && !busy; i++) begin @(negedge clock); #1; end
    clr = 1'b1;
    repeat (2) @(negedge clock);
    clr = 1'b0;
    push(0, 0);
    wait_obs(0, 4, ok);
    checks++; if (!ok) $display("FAIL clear_busy_timeout: got %0d writes want 4", obs[0].size()); else passes++;
    if (ok)
      for (int j = 2; j < 4; j++) begin
        checks++; if (obs[0][j] != expq[0][j]) $display("FAIL clear_ignored[%0d]: got %0d want %0d", j, obs[0][j], expq[0][j]); else passes++;
      end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 24; i++) begin push(0, rv()); push(1, rv()); end
    for (int i = 0; i < 3000 && (obs[0].size() < 24 || obs[1].size() < 24); i++) begin
      @(negedge clock);
      out_full = 2'($urandom_range(0, 3));
      #1;
    end
    out_full = 2'b00;
    checks++; if (obs[0].size() != 24 || obs[1].size() != 24) $display("FAIL rand_count: got %0d/%0d want 24/24", obs[0].size(), obs[1].size()); else passes++;
    for (int c = 0; c < 2; c++)
      for (int j = 0; j < obs[c].size() && j < 24; j++) begin
        checks++; if (obs[c][j] != expq[c][j]) $display("FAIL rand_value ch%0d[%0d]: got %0d want %0d", c, j, obs[c][j], expq[c][j]); else passes++;
      end
    checks++; if (viol != 0) $display("FAIL rand_strobes: got %0d illegal strobe cycles want 0", viol); else passes++;
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_impulse();
    test_rounding();
    test_backpressure();
    test_reset_midop();
    test_clear();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
